// File: rtl/flash_phy_scramble_arb.sv
// rtl/flash_phy_scramble_arb.sv - round-robin front end sharing one pipelined scramble cipher engine
// Optional engine response timeout: FLASH_SCRAMBLE_TIMEOUT_EN.
module flash_phy_scramble_arb #(
   parameter int NumReq     = 2,
   parameter int DataWidth  = 64,
   parameter int KeySize    = 128,
   parameter int Depth      = 2,
   parameter int TimeoutCyc = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        disable_i,
   input  logic [NumReq-1:0]           req_i,
   input  logic [NumReq-1:0]           op_type_i,
   input  logic [NumReq*DataWidth-1:0] data_i,
   input  logic [KeySize-1:0]          data_key_i,
   input  logic [KeySize-1:0]          rand_data_key_i,
   output logic [NumReq-1:0]           ack_o,
   output logic [DataWidth-1:0]        data_o,
   output logic                        eng_valid_o,
   input  logic                        eng_ready_i,
   output logic                        eng_dec_o,
   output logic [DataWidth-1:0]        eng_data_o,
   output logic [KeySize-1:0]          eng_key_o,
   input  logic                        eng_valid_i,
   input  logic [DataWidth-1:0]        eng_data_i,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [NumReq-1:0] inflight, eligible, issue_mask;
   logic [IdW-1:0]    rr_ptr, grant, grant_next, head;
   logic [IdW-1:0]    tag_mem [Depth];
   logic [PtrW-1:0]   wr_ptr, rd_ptr;
   logic [CntW-1:0]   count;
   logic              key_sel, fifo_empty, fifo_full, issue, pop, flush, found;
   int                idx;

   function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign eligible   = req_i & ~inflight;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CntW'(Depth));
   assign head       = tag_mem[rd_ptr];
   assign pop        = eng_valid_i & ~fifo_empty;

   // Round-robin search starting at rr_ptr, wrapping.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NumReq; i++) begin
         idx = (int'(rr_ptr) + i) % NumReq;
         if (!found && eligible[idx]) begin
            grant = IdW'(idx);
            found = 1'b1;
         end
      end
   end

   assign grant_next = (grant == IdW'(NumReq - 1)) ? '0 : grant + 1'b1;

`ifdef FLASH_SCRAMBLE_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCyc + 1);
   logic [TmoW-1:0] tmo_cnt;

   // A pop in the expiry cycle wins; the remaining ops get a fresh window.
   assign flush = ~fifo_empty & ~pop & (tmo_cnt == TmoW'(TimeoutCyc - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt <= '0;
      end else if (pop || fifo_empty || flush) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   assign eng_valid_o = (|eligible) & ~fifo_full & ~flush;
   assign issue       = eng_valid_o & eng_ready_i;
   assign eng_dec_o   = op_type_i[grant];
   assign eng_data_o  = data_i[int'(grant)*DataWidth +: DataWidth];
   assign eng_key_o   = key_sel ? rand_data_key_i : data_key_i;
   assign busy_o      = ~fifo_empty | (|inflight);

   always_comb begin
      issue_mask = '0;
      if (issue) issue_mask[grant] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) tag_mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rr_ptr   <= '0;
         inflight <= '0;
         ack_o    <= '0;
         data_o   <= '0;
         err_o    <= 1'b0;
         key_sel  <= 1'b0;
      end else begin
         if (issue) begin
            tag_mem[wr_ptr] <= grant;
            wr_ptr          <= inc_ptr(wr_ptr);
            rr_ptr          <= grant_next;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop) rd_ptr <= inc_ptr(rd_ptr);
            if (issue && !pop) count <= count + 1'b1;
            else if (!issue && pop) count <= count - 1'b1;
         end
         // An owner is released at the end of its ack cycle.
         inflight <= (inflight | issue_mask) & ~ack_o;
         ack_o    <= '0;
         if (pop) begin
            ack_o[head] <= 1'b1;
            data_o      <= eng_data_i;
         end else if (flush) begin
            ack_o  <= inflight & ~ack_o;
            data_o <= '0;
         end
         if ((eng_valid_i && fifo_empty) || flush) err_o <= 1'b1;
         if (fifo_empty && !issue) key_sel <= disable_i;
      end
   end

endmodule

// File: tb/tb_flash_phy_scramble_arb.sv
// tb/tb_flash_phy_scramble_arb.sv - directed self-checking bench for flash_phy_scramble_arb
module tb_flash_phy_scramble_arb;

   localparam int NR = 3;
   localparam int DW = 64;
   localparam int KS = 128;

   localparam logic [DW-1:0] D0 = 64'hDDDD_0000_0000_00A0;
   localparam logic [DW-1:0] D1 = 64'hDDDD_0000_0000_00A1;
   localparam logic [DW-1:0] D2 = 64'hDDDD_0000_0000_00A2;
   localparam logic [DW-1:0] R0 = 64'h5A5A_0000_0000_0010;
   localparam logic [DW-1:0] R1 = 64'h5A5A_0000_0000_0011;
   localparam logic [DW-1:0] R2 = 64'h5A5A_0000_0000_0012;
   localparam logic [DW-1:0] R3 = 64'h5A5A_0000_0000_0013;
   localparam logic [KS-1:0] K0 = {4{32'h1111_1111}};
   localparam logic [KS-1:0] K1 = {4{32'h2222_2222}};

   logic             clk, rst_n, dis;
   logic [NR-1:0]    req, op_type, ack;
   logic [NR*DW-1:0] data_in;
   logic [DW-1:0]    data_out, eng_wdata, eng_rdata;
   logic             eng_valid_out, eng_ready, eng_dec, eng_valid_in, busy, err;
   logic [KS-1:0]    eng_key;

   int checks = 0;
   int errors = 0;

   flash_phy_scramble_arb #(
      .NumReq(NR), .DataWidth(DW), .KeySize(KS), .Depth(2), .TimeoutCyc(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .disable_i(dis),
      .req_i(req), .op_type_i(op_type), .data_i(data_in),
      .data_key_i(K0), .rand_data_key_i(K1),
      .ack_o(ack), .data_o(data_out),
      .eng_valid_o(eng_valid_out), .eng_ready_i(eng_ready), .eng_dec_o(eng_dec),
      .eng_data_o(eng_wdata), .eng_key_o(eng_key),
      .eng_valid_i(eng_valid_in), .eng_data_i(eng_rdata),
      .busy_o(busy), .err_o(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; dis = 1'b0; req = '0; op_type = '0;
      data_in = {D2, D1, D0};
      eng_ready = 1'b0; eng_valid_in = 1'b0; eng_rdata = '0;
      step(); step();
      check("rst_ack", ack, 0);
      check("rst_data", data_out, 0);
      check("rst_valid", eng_valid_out, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      // Two requesters issue in order and are acked in order
      req = 3'b011; op_type = 3'b010; eng_ready = 1'b1; #1;
      check("t1_valid", eng_valid_out, 1);
      check("t1_data0", eng_wdata, D0);
      check("t1_dec0", eng_dec, 0);
      check("t1_key", eng_key, K0);
      step();
      check("t1_busy", busy, 1);
      check("t1_data1", eng_wdata, D1);
      check("t1_dec1", eng_dec, 1);
      step();
      eng_ready = 1'b0; eng_valid_in = 1'b1; eng_rdata = R0; #1;
      check("t1_no_valid", eng_valid_out, 0);
      step();
      check("t1_ack0", ack, 3'b001);
      check("t1_rdata0", data_out, R0);
      req = 3'b010; eng_rdata = R1;
      step();
      check("t1_ack1", ack, 3'b010);
      check("t1_rdata1", data_out, R1);
      req = '0; eng_valid_in = 1'b0;
      step();
      check("t1_ack_clr", ack, 0);
      check("t1_idle_busy", busy, 0);

      // Depth limit: third requester waits for the first pop (rr_ptr is 2 here)
      req = 3'b111; eng_ready = 1'b1; #1;
      check("t2_grant2", eng_wdata, D2);
      step();
      check("t2_grant0", eng_wdata, D0);
      check("t2_valid0", eng_valid_out, 1);
      step();
      check("t2_full", eng_valid_out, 0);
      step();
      check("t2_full_hold", eng_valid_out, 0);
      eng_valid_in = 1'b1; eng_rdata = R2; #1;
      check("t2_pop_cycle", eng_valid_out, 0);
      step();
      check("t2_ack2", ack, 3'b100);
      check("t2_rdata2", data_out, R2);
      check("t2_third_valid", eng_valid_out, 1);
      check("t2_third_data", eng_wdata, D1);
      req = 3'b011; eng_valid_in = 1'b0;
      step();
      eng_valid_in = 1'b1; eng_rdata = R0;
      step();
      check("t2_ack0", ack, 3'b001);
      check("t2_rdata0", data_out, R0);
      req = 3'b010; eng_rdata = R1;
      step();
      check("t2_ack1", ack, 3'b010);
      check("t2_rdata1", data_out, R1);
      req = '0; eng_valid_in = 1'b0;
      step();
      check("t2_idle_busy", busy, 0);

      // Key select frozen while an op is in flight
      req = 3'b001; eng_ready = 1'b1; #1;
      check("t3_key_idle", eng_key, K0);
      step();
      dis = 1'b1; #1;
      check("t3_key_inflight", eng_key, K0);
      step();
      check("t3_key_hold", eng_key, K0);
      eng_valid_in = 1'b1; eng_rdata = R3;
      step();
      check("t3_ack", ack, 3'b001);
      check("t3_key_ack", eng_key, K0);
      req = '0; eng_valid_in = 1'b0;
      step();
      check("t3_key_rand", eng_key, K1);

      // Spurious engine response
      eng_valid_in = 1'b1;
      step();
      check("t4_no_ack", ack, 0);
      check("t4_err", err, 1);
      eng_valid_in = 1'b0;
      step(); step();
      check("t4_err_sticky", err, 1);

      // Reset with two ops in flight (leaves rr_ptr at 1)
      dis = 1'b0; req = 3'b011; eng_ready = 1'b1;
      step(); step();
      check("t5_busy", busy, 1);
      check("t5_key_held", eng_key, K1);
      rst_n = 1'b0; req = '0; eng_ready = 1'b0;
      step();
      check("t5_ack", ack, 0);
      check("t5_data", data_out, 0);
      check("t5_busy_rst", busy, 0);
      check("t5_err_rst", err, 0);
      check("t5_key_rst", eng_key, K0);
      rst_n = 1'b1; req = 3'b111; #1;
      check("t5_rr_valid", eng_valid_out, 1);
      check("t5_rr_grant", eng_wdata, D0);
      req = '0; eng_valid_in = 1'b1;
      step();
      check("t5_fifo_empty_err", err, 1);
      check("t5_fifo_empty_ack", ack, 0);
      eng_valid_in = 1'b0;

`ifdef FLASH_SCRAMBLE_TIMEOUT_EN
      // Silent engine times out after 8 cycles
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; eng_rdata = R3;
      step();
      req = 3'b001; eng_ready = 1'b1;
      step();
      eng_ready = 1'b0;
      repeat (7) step();
      check("t6_err_early", err, 0);
      check("t6_ack_early", ack, 0);
      step();
      check("t6_err", err, 1);
      check("t6_ack", ack, 3'b001);
      check("t6_data", data_out, 0);
      req = '0;
      step();
      check("t6_ack_clr", ack, 0);
      check("t6_busy", busy, 0);
      eng_valid_in = 1'b1;
      step();
      eng_valid_in = 1'b0;
      check("t6_late_ack", ack, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
